// File: rtl/jtag_master.sv
// jtag_master: host-side JTAG driver running TAP-reset, IR/DR scans and idle clocks, parking the TAP in Run-Test/Idle
module jtag_master #(
  parameter int CLK_DIV = 2,
  parameter int DATA_W  = 32,
  parameter int LEN_W   = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic              tck,
  output logic              tms,
  output logic              tdi,
  input  logic              tdo
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  typedef enum logic [2:0] {IDLE, RST_SEQ, PRE, SHIFT, POST, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [LEN_W-1:0] cnt_q, cnt_d, len_q, len_d, slen;
  logic [DATA_W-1:0] data_q, data_d, cap_q, cap_d, mask_q, mask_d, rsp_q, rsp_d;
  logic ir_q, ir_d, auto_q, auto_d, tck_q, tck_d, tms_q, tms_d, tdi_q, tdi_d;
  logic half_end, last;
  assign cmd_ready = state_q == IDLE || state_q == DONE;
  assign busy      = !cmd_ready;
  assign rsp_valid = state_q == DONE;
  assign rsp_data  = rsp_q;
  assign tck       = tck_q;
  assign tms       = tms_q;
  assign tdi       = tdi_q;
  assign half_end  = div_q == DW'(CLK_DIV - 1);
  assign slen      = cmd_len == '0 ? LEN_W'(1) : cmd_len > LEN_W'(DATA_W) ? LEN_W'(DATA_W) : cmd_len;
  // index of the final TCK period of the current phase
  assign last = cnt_q == (state_q == RST_SEQ ? LEN_W'(5) : state_q == PRE ? (ir_q ? LEN_W'(3) : LEN_W'(2)) :
                          state_q == POST ? LEN_W'(1) : len_q - 1'b1);
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    ir_d    = ir_q;
    auto_d  = auto_q;
    data_d  = data_q;
    cap_d   = cap_q;
    mask_d  = mask_q;
    rsp_d   = rsp_q;
    tck_d   = tck_q;
    tms_d   = tms_q;
    tdi_d   = tdi_q;
    if (cmd_ready) begin
      state_d = IDLE;
      tms_d   = 1'b0;
      tdi_d   = 1'b0;
      if (cmd_valid) begin
        state_d = cmd_op == 2'b00 ? RST_SEQ : cmd_op == 2'b11 ? (cmd_len == '0 ? DONE : RUN) : PRE;
        auto_d  = 1'b0;
        ir_d    = cmd_op == 2'b01;
        len_d   = cmd_op == 2'b11 ? cmd_len : slen;
        cnt_d   = '0;
        div_d   = '0;
        data_d  = cmd_data;
        cap_d   = '0;
        mask_d  = DATA_W'(1);
        tms_d   = cmd_op != 2'b11;
      end
    end else if (!half_end) begin
      div_d = div_q + 1'b1;
    end else begin
      div_d = '0;
      tck_d = !tck_q;
      if (!tck_q) begin
        cap_d = (state_q == SHIFT && tdo) ? cap_q | mask_q : cap_q;
      end else begin
        state_d = !last ? state_q : state_q == RST_SEQ ? (auto_q ? IDLE : DONE) :
                  state_q == PRE ? SHIFT : state_q == SHIFT ? POST : DONE;
        cnt_d   = last ? '0 : cnt_q + 1'b1;
        if (state_q == SHIFT) begin
          data_d = data_q >> 1;
          mask_d = mask_q << 1;
        end
        if (state_q == POST && last) rsp_d = cap_q;
        tms_d = state_d == RST_SEQ ? cnt_d < LEN_W'(5) :
                state_d == PRE ? (ir_q ? cnt_d < LEN_W'(2) : cnt_d == '0) :
                state_d == SHIFT ? cnt_d == len_q - 1'b1 : state_d == POST && cnt_d == '0;
        tdi_d = state_d == SHIFT && data_d[0];
      end
    end
  end
  // reset values double as the first period of the automatic TAP reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RST_SEQ;
      div_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      ir_q    <= 1'b0;
      auto_q  <= 1'b1;
      data_q  <= '0;
      cap_q   <= '0;
      mask_q  <= '0;
      rsp_q   <= '0;
      tck_q   <= 1'b0;
      tms_q   <= 1'b1;
      tdi_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      ir_q    <= ir_d;
      auto_q  <= auto_d;
      data_q  <= data_d;
      cap_q   <= cap_d;
      mask_q  <= mask_d;
      rsp_q   <= rsp_d;
      tck_q   <= tck_d;
      tms_q   <= tms_d;
      tdi_q   <= tdi_d;
    end
  end
endmodule

// File: tb/tb_jtag_master.sv
// tb_jtag_master: directed scenarios against jtag_master driving a behavioural 4-bit-IR TAP
module tb_jtag_master;
  logic        clk = 0, rst_n = 0, cmd_valid = 0, tdo = 0;
  logic [1:0]  cmd_op = 0;
  logic [5:0]  cmd_len = 0;
  logic [31:0] cmd_data = 0;
  logic        cmd_ready, rsp_valid, busy, tck, tms, tdi;
  logic [31:0] rsp_data;
  int tests = 0, fails = 0, rsp_cnt = 0;
  logic tms_log[$], tdi_log[$];
  time  tck_t[$];

  jtag_master #(.CLK_DIV(2), .DATA_W(32), .LEN_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_len(cmd_len), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .busy(busy), .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo));

  always #5 clk = ~clk;

  always @(posedge tck) begin
    tms_log.push_back(tms);
    tdi_log.push_back(tdi);
    tck_t.push_back($time);
  end

  always @(negedge clk) if (rsp_valid) rsp_cnt <= rsp_cnt + 1;

  // Target TAP: IR captures 0001, IR=8 selects a 32-bit register capturing F0F0F0F0, all else bypass
  localparam logic [3:0] TLR = 0, RTI = 1, SDS = 2, CDR = 3, SHD = 4, E1D = 5, PDR = 6, E2D = 7,
                         UDR = 8, SIS = 9, CIR = 10, SHI = 11, E1I = 12, PIR = 13, E2I = 14, UIR = 15;
  logic [3:0]  ts = TLR, ir = 4'hF, ir_sr = 0;
  logic [31:0] dr_sr = 0;
  logic        byp = 0;

  function automatic logic [3:0] tnext(input logic [3:0] s, input logic m);
    case (s)
      TLR: return m ? TLR : RTI;
      RTI: return m ? SDS : RTI;
      SDS: return m ? SIS : CDR;
      CDR: return m ? E1D : SHD;
      SHD: return m ? E1D : SHD;
      E1D: return m ? UDR : PDR;
      PDR: return m ? E2D : PDR;
      E2D: return m ? UDR : SHD;
      UDR: return m ? SDS : RTI;
      SIS: return m ? TLR : CIR;
      CIR: return m ? E1I : SHI;
      SHI: return m ? E1I : SHI;
      E1I: return m ? UIR : PIR;
      PIR: return m ? E2I : PIR;
      E2I: return m ? UIR : SHI;
      default: return m ? SDS : RTI;
    endcase
  endfunction

  always @(posedge tck) begin
    case (ts)
      TLR: ir <= 4'hF;
      CIR: ir_sr <= 4'b0001;
      SHI: ir_sr <= {tdi, ir_sr[3:1]};
      UIR: ir <= ir_sr;
      CDR: begin dr_sr <= 32'hF0F0F0F0; byp <= 1'b0; end
      SHD: if (ir == 4'h8) dr_sr <= {tdi, dr_sr[31:1]}; else byp <= tdi;
      default: ;
    endcase
    ts <= tnext(ts, tms);
  end

  always @(negedge tck) tdo <= ts == SHI ? ir_sr[0] : ts == SHD ? (ir == 4'h8 ? dr_sr[0] : byp) : 1'b0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] pack(input logic q[$]);
    logic [63:0] v = '0;
    foreach (q[i]) if (i < 64) v[i] = q[i];
    return v;
  endfunction

  task automatic clear_logs();
    tms_log.delete();
    tdi_log.delete();
    tck_t.delete();
  endtask

  task automatic send(input logic [1:0] op, input logic [5:0] len, input logic [31:0] d);
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 2000) begin @(negedge clk); n++; end
    tests++;
    if (cmd_ready !== 1'b1) begin fails++; $display("FAIL send_ready: cmd_ready=%b required 1", cmd_ready); end
    cmd_valid = 1; cmd_op = op; cmd_len = len; cmd_data = d;
    @(posedge clk);
    #1 cmd_valid = 0; cmd_op = 2'b11; cmd_len = 6'h3F; cmd_data = 32'hDEADBEEF;
  endtask

  task automatic wait_rsp();
    int n = 0;
    logic ok = 0;
    while (n < 2000) begin
      @(negedge clk);
      if (rsp_valid) begin ok = 1; break; end
      n++;
    end
    tests++;
    if (!ok) begin fails++; $display("FAIL wait_rsp: rsp_valid never seen within 2000 cycles"); end
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!cmd_ready && n < 2000) begin @(negedge clk); n++; end
    tests++;
    if (cmd_ready !== 1'b1) begin fails++; $display("FAIL %s: cmd_ready=%b required 1", name, cmd_ready); end
  endtask

  task automatic test_reset();
    logic bad = 0;
    #12;
    tests++;
    if ({tck, tms, tdi, cmd_ready, rsp_valid, busy} !== 6'b010001 || rsp_data !== 32'h0) begin
      fails++;
      $display("FAIL reset_values: tck/tms/tdi/rdy/rv/busy=%b rsp=%h required 010001 0", {tck, tms, tdi, cmd_ready, rsp_valid, busy}, rsp_data);
    end
    clear_logs();
    @(negedge clk) rst_n = 1;
    wait_ready("reset_ready");
    #1;
    tests++;
    if (tms_log.size() != 6 || pack(tms_log) !== 64'h1F) begin
      fails++; $display("FAIL reset_tms: n=%0d tms=%h required n=6 tms=1f", tms_log.size(), pack(tms_log));
    end
    for (int i = 1; i < tck_t.size(); i++) if (tck_t[i] - tck_t[i-1] != 40) bad = 1;
    tests++;
    if (bad) begin fails++; $display("FAIL reset_period: tck period not 40ns (4 clk), got bad=%b required 0", bad); end
    tests++;
    if ({busy, tck, tms, tdi} !== 4'b0000 || ts !== RTI || rsp_cnt != 0) begin
      fails++; $display("FAIL reset_idle: busy/tck/tms/tdi=%b tap=%0d rsp_cnt=%0d required 0000 1 0", {busy, tck, tms, tdi}, ts, rsp_cnt);
    end
  endtask

  task automatic test_ir_scan();
    int c = rsp_cnt;
    clear_logs();
    send(2'b01, 6'd4, 32'h8);
    wait_rsp();
    tests++;
    if (rsp_data !== 32'h1) begin fails++; $display("FAIL ir_rsp: rsp_data=%h required 00000001", rsp_data); end
    tests++;
    if (tms_log.size() != 10 || pack(tms_log) !== 64'h183) begin
      fails++; $display("FAIL ir_tms: n=%0d tms=%h required n=10 tms=183", tms_log.size(), pack(tms_log));
    end
    tests++;
    if (pack(tdi_log) !== 64'h80) begin fails++; $display("FAIL ir_tdi: tdi=%h required 80", pack(tdi_log)); end
    repeat (20) @(negedge clk);
    #1;
    tests++;
    if (rsp_cnt - c != 1 || ts !== RTI || ir !== 4'h8 || {tck, tms, tdi} !== 3'b000) begin
      fails++; $display("FAIL ir_after: pulses=%0d tap=%0d ir=%h pins=%b required 1 1 8 000", rsp_cnt - c, ts, ir, {tck, tms, tdi});
    end
  endtask

  task automatic test_dr_scan();
    clear_logs();
    send(2'b10, 6'd32, 32'h0);
    wait_rsp();
    tests++;
    if (rsp_data !== 32'hF0F0F0F0) begin fails++; $display("FAIL dr_rsp: rsp_data=%h required f0f0f0f0", rsp_data); end
    tests++;
    if (tms_log.size() != 37 || pack(tms_log) !== 64'hC_0000_0001) begin
      fails++; $display("FAIL dr_tms: n=%0d tms=%h required n=37 tms=c00000001", tms_log.size(), pack(tms_log));
    end
  endtask

  task automatic test_bypass();
    send(2'b01, 6'd4, 32'h0);
    wait_rsp();
    clear_logs();
    send(2'b10, 6'd8, 32'hA5);
    wait_rsp();
    tests++;
    if (rsp_data !== 32'h4A) begin fails++; $display("FAIL bypass_rsp: rsp_data=%h required 0000004a", rsp_data); end
    tests++;
    if (tms_log.size() != 13 || pack(tms_log) !== 64'hC01 || pack(tdi_log) !== 64'h528) begin
      fails++; $display("FAIL bypass_pins: n=%0d tms=%h tdi=%h required 13 c01 528", tms_log.size(), pack(tms_log), pack(tdi_log));
    end
  endtask

  task automatic test_clamp();
    clear_logs();
    send(2'b10, 6'd0, 32'hFFFFFFFF);
    wait_rsp();
    tests++;
    if (tms_log.size() != 6 || pack(tms_log) !== 64'h19 || rsp_data !== 32'h0) begin
      fails++; $display("FAIL clamp_len0: n=%0d tms=%h rsp=%h required 6 19 0", tms_log.size(), pack(tms_log), rsp_data);
    end
    clear_logs();
    send(2'b10, 6'd40, 32'hFFFFFFFF);
    wait_rsp();
    tests++;
    if (tms_log.size() != 37 || pack(tms_log) !== 64'hC_0000_0001 || rsp_data !== 32'hFFFFFFFE) begin
      fails++; $display("FAIL clamp_len40: n=%0d tms=%h rsp=%h required 37 c00000001 fffffffe", tms_log.size(), pack(tms_log), rsp_data);
    end
  endtask

  task automatic test_run_idle();
    logic [31:0] prev = rsp_data;
    clear_logs();
    send(2'b11, 6'd0, 32'hFFFFFFFF);
    @(negedge clk);
    tests++;
    if (rsp_valid !== 1'b1) begin fails++; $display("FAIL run0_rsp: rsp_valid=%b required 1 one clk after accept", rsp_valid); end
    @(negedge clk);
    tests++;
    if (rsp_valid !== 1'b0) begin fails++; $display("FAIL run0_pulse: rsp_valid=%b required 0 in second cycle", rsp_valid); end
    repeat (10) @(negedge clk);
    tests++;
    if (tck_t.size() != 0 || rsp_data !== prev) begin
      fails++; $display("FAIL run0_tck: tck rises=%0d rsp=%h required 0 %h", tck_t.size(), rsp_data, prev);
    end
    send(2'b11, 6'd3, 32'hFFFFFFFF);
    wait_rsp();
    tests++;
    if (tms_log.size() != 3 || pack(tms_log) !== 64'h0 || pack(tdi_log) !== 64'h0 || rsp_data !== prev) begin
      fails++; $display("FAIL run3: n=%0d tms=%h tdi=%h rsp=%h required 3 0 0 %h", tms_log.size(), pack(tms_log), pack(tdi_log), rsp_data, prev);
    end
  endtask

  task automatic test_tap_reset_cmd();
    logic [31:0] prev = rsp_data;
    send(2'b01, 6'd4, 32'h8);
    wait_rsp();
    prev = rsp_data;
    clear_logs();
    send(2'b00, 6'd9, 32'hFFFFFFFF);
    wait_rsp();
    tests++;
    if (tms_log.size() != 6 || pack(tms_log) !== 64'h1F || pack(tdi_log) !== 64'h0 || rsp_data !== prev) begin
      fails++; $display("FAIL tap_reset_cmd: n=%0d tms=%h tdi=%h rsp=%h required 6 1f 0 %h", tms_log.size(), pack(tms_log), pack(tdi_log), rsp_data, prev);
    end
    #1;
    tests++;
    if (ir !== 4'hF || ts !== RTI) begin fails++; $display("FAIL tap_reset_state: ir=%h tap=%0d required f 1", ir, ts); end
  endtask

  task automatic test_back_to_back();
    send(2'b01, 6'd4, 32'h0);
    wait_rsp();
    tests++;
    if ({cmd_ready, busy} !== 2'b10) begin fails++; $display("FAIL b2b_ready: ready/busy=%b required 10 during rsp_valid", {cmd_ready, busy}); end
    cmd_valid = 1; cmd_op = 2'b10; cmd_len = 6'd8; cmd_data = 32'h3C;
    @(posedge clk);
    #1 cmd_valid = 0; cmd_data = 32'h0;
    @(negedge clk);
    tests++;
    if ({busy, rsp_valid} !== 2'b10) begin fails++; $display("FAIL b2b_accept: busy/rsp_valid=%b required 10", {busy, rsp_valid}); end
    wait_rsp();
    tests++;
    if (rsp_data !== 32'h78) begin fails++; $display("FAIL b2b_rsp: rsp_data=%h required 00000078", rsp_data); end
  endtask

  task automatic test_abort();
    int c, n = 0;
    send(2'b10, 6'd32, 32'h0);
    while (n < 2000 && !(tms_log.size() >= 8 && tck)) begin @(posedge clk); #1; n++; end
    c = rsp_cnt;
    rst_n = 0;
    #1;
    tests++;
    if ({tck, tms, cmd_ready, busy, rsp_valid} !== 5'b01010) begin
      fails++; $display("FAIL abort_pins: tck/tms/rdy/busy/rv=%b required 01010", {tck, tms, cmd_ready, busy, rsp_valid});
    end
    clear_logs();
    repeat (3) @(negedge clk);
    rst_n = 1;
    wait_ready("abort_ready");
    repeat (5) @(negedge clk);
    #1;
    tests++;
    if (tms_log.size() != 6 || pack(tms_log) !== 64'h1F || rsp_cnt != c || ts !== RTI || ir !== 4'hF) begin
      fails++; $display("FAIL abort_rerun: n=%0d tms=%h pulses=%0d tap=%0d ir=%h required 6 1f 0 1 f", tms_log.size(), pack(tms_log), rsp_cnt - c, ts, ir);
    end
  endtask

  initial begin
    test_reset();
    test_ir_scan();
    test_dr_scan();
    test_bypass();
    test_clamp();
    test_run_idle();
    test_tap_reset_cmd();
    test_back_to_back();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
